// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter (byte FIFO + bit serializer)
module uart_tx_buffered #(
  parameter int BAUD_DIV = 103,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              txd,
  output logic              tx_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              push_drop
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0]     BAUD_RELOAD = 12'(BAUD_DIV);
  localparam logic [ADDR_W:0] FULL_COUNT  = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop, fifo_empty, bit_end;

  state_t      state, state_next;
  logic [11:0] baud_cnt, baud_next;
  logic [2:0]  bit_idx, bit_next;
  logic [7:0]  shift, shift_next;
  logic        txd_next;

  assign in_ready   = (fifo_count != FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid & in_ready & ~flush;
  assign bit_end    = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      push_drop  <= 1'b0;
    end else begin
      push_drop <= in_valid & ~in_ready;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      txd      <= txd_next;
      tx_busy  <= (state != IDLE) | ~fifo_empty;
    end
  end

  // Pops are blocked during flush so the cleared FIFO never feeds a new frame.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    txd_next   = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = BAUD_RELOAD;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (bit_end) begin
          baud_next  = BAUD_RELOAD;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        txd_next = shift[0];
        if (bit_end) begin
          baud_next  = BAUD_RELOAD;
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        txd_next = 1'b1;
        if (bit_end) begin
          baud_next = BAUD_RELOAD;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty && !flush) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter: byte FIFO in front of a bit serializer.
- Lets the command/cipher path push reply strings in bursts with a valid/ready handshake, instead of waiting on tx_busy for every byte.
- Drives the FTDI TX pin. It is the outbound counterpart of the UART receive path.
- Frame timing is identical to the receive side: same BAUD_DIV convention, LSB first, 1 start bit, 1 stop bit.

Parameters:
- BAUD_DIV, 103: bit period minus one, in clk cycles. Default gives 104 clocks, which is 115200 baud at 12 MHz. Legal range 1..4095.
- DEPTH, 16: FIFO entries. Must be a power of two, 2..256.
- ADDR_W, 4: log2(DEPTH). Must match DEPTH.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  asynchronous active-high reset.
- in_byte  in  8  byte to enqueue.
- in_valid  in  1  in_byte is valid this cycle.
- in_ready  out  1  FIFO can accept a byte this cycle.
- flush  in  1  synchronous FIFO clear; an in-flight frame completes.
- txd  out  1  serial output, idle high.
- tx_busy  out  1  serializer active or FIFO non-empty.
- fifo_count  out  ADDR_W+1  number of bytes stored.
- push_drop  out  1  one-cycle pulse: in_valid asserted while in_ready low.

Behaviour:
- Reset (async assert, sync release)
  - Outputs: txd=1, in_ready=1, tx_busy=0, fifo_count=0, push_drop=0.
  - Internal: pointers=0, state=IDLE, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately and forces txd=1.
- FIFO
  - in_ready = (fifo_count != DEPTH), purely from registered count.
  - Push occurs on a clock edge with in_valid & in_ready.
  - When full, a push is refused even if a pop happens the same cycle. No pass-through.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
  - push_drop is registered: high the cycle after in_valid & !in_ready. The byte is discarded.
  - flush has priority over push in the same cycle. Pointers and count go to 0 and the pushed byte is discarded.
  - flush does not touch the serializer.
- Serializer FSM (states IDLE, START, DATA, STOP)
  - IDLE: txd=1. If fifo_count!=0 and flush=0: pop the head byte into the shift register, load baud counter=BAUD_DIV, go to START.
  - START: txd=0 for BAUD_DIV+1 clocks. Then bit index=0 and go to DATA.
  - DATA: txd=shift[0] for BAUD_DIV+1 clocks per bit, shifting right. After bit 7, go to STOP.
  - STOP: txd=1 for BAUD_DIV+1 clocks.
    - On the last stop-bit cycle, if FIFO is non-empty: pop and go directly to START. No idle gap between frames.
    - Otherwise go to IDLE.
  - Baud counter counts down. A bit ends when counter==0, then reloads BAUD_DIV.
  - txd is registered (no glitches).
- Latency and timing
  - Push into empty FIFO with serializer in IDLE at edge N: pop at edge N+1, txd falls after edge N+2.
  - The falling edge of txd is the frame start.
  - One frame is exactly 10*(BAUD_DIV+1) clocks.
  - Back-to-back frames: the stop bit of frame k is immediately followed by the start bit of frame k+1.
- tx_busy = (state != IDLE) | (fifo_count != 0), registered-equivalent.
  - Goes low in the first IDLE cycle after the last stop bit when the FIFO is empty.
- fifo_count decrements on the pop edge. The popped byte is no longer counted while it is being serialized.

Test Plan:
- Idle after reset (BAUD_DIV=103): 50 clocks with no input -> txd=1, in_ready=1, tx_busy=0, fifo_count=0.
- Single byte: push 0x41 at cycle 0 -> txd low from cycle 2.
  - Bits 1,0,0,0,0,0,1,0 (LSB first), each 104 clocks, then stop high.
  - tx_busy falls at cycle 1042.
  - Decoded by the bench UART model as 0x41.
- Burst: push "ENIGMA\r\n" (8 bytes) on consecutive cycles -> fifo_count peaks at 7.
  - 8 contiguous frames, total 8320 clocks from first start bit, no idle gap.
  - Decoded stream matches the input exactly.
- Full and drop (DEPTH=16): push 18 bytes back-to-back.
  - One pop frees a slot, so 17 are accepted, in_ready drops when count reaches 16, and push_drop pulses once.
  - 17 bytes are transmitted in order.
- Flush mid-frame: push 0x55,0xAA,0x0F; assert flush during the first frame's bit 3.
  - Frame 0x55 completes intact, fifo_count=0 the next cycle, no further frames.
  - Same-cycle push with flush is discarded.
- Reset mid-frame: assert rst during DATA of 0x5A -> txd=1 asynchronously and all outputs at reset values.
  - After release, push 0x5A -> clean frame, decoded 0x5A.
